// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

  localparam int NW_DEF = 16;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] DIV0_QUOT = 16'hFFFF;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   p,
  input  logic          bit_in,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   p_next,
  output logic          q_bit
);

  logic [DW+1:0] shifted;
  logic [DW+1:0] t;

  // One guard bit above P so the sign of the trial difference is explicit.
  assign shifted = {p, bit_in};
  assign t       = shifted - {2'b00, divisor};
  assign q_bit   = ~t[DW+1];
  assign p_next  = q_bit ? t[DW:0] : shifted[DW:0];

endmodule

// File: rtl/seq_div_16.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module seq_div_16
  import div_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_zero
);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [DW:0]   p, p_next;
  logic [NW-1:0] q, q_shift;
  logic [DW-1:0] dvs;
  logic          q_bit;
  logic          last;
  logic [NW-1:0] op_a, q_final;
  logic [DW-1:0] op_b, r_final;

  div_step #(.DW(DW)) u_step (
    .p      (p),
    .bit_in (q[NW-1]),
    .divisor(dvs),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  assign q_shift  = {q[NW-2:0], q_bit};
  assign last     = (cnt == CW'(NW - 1));
  assign in_ready = (state == IDLE);

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  // Most-negative values map onto their own bit pattern, which is the correct magnitude.
  assign op_a    = dividend[NW-1] ? -dividend : dividend;
  assign op_b    = divisor[DW-1] ? -divisor : divisor;
  assign q_final = neg_q ? -q_shift : q_shift;
  assign r_final = neg_r ? -p_next[DW-1:0] : p_next[DW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      neg_q <= dividend[NW-1] ^ divisor[DW-1];
      neg_r <= dividend[NW-1];
    end
  end
`else
  assign op_a    = dividend;
  assign op_b    = divisor;
  assign q_final = q_shift;
  assign r_final = p_next[DW-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = (divisor == '0) ? DONE : CALC;
      CALC:    if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      p         <= '0;
      q         <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
      out_valid <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quotient  <= NW'(DIV0_QUOT);
              remainder <= dividend[DW-1:0];
              div_zero  <= 1'b1;
              out_valid <= 1'b1;
            end else begin
              p        <= '0;
              q        <= op_a;
              dvs      <= op_b;
              cnt      <= '0;
              div_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          p   <= p_next;
          q   <= q_shift;
          cnt <= cnt + 1'b1;
          // The final step feeds the result registers directly, saving a cycle.
          if (last) begin
            quotient  <= q_final;
            remainder <= r_final;
            div_zero  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
